// File: rtl/am2910_pkg.sv
// Shared opcodes, controller states and the am2910 push/pop/load/decrement decode.
package am2910_pkg;

  localparam logic [3:0] OP_JZ   = 4'd0;
  localparam logic [3:0] OP_CJS  = 4'd1;
  localparam logic [3:0] OP_JMAP = 4'd2;
  localparam logic [3:0] OP_CJP  = 4'd3;
  localparam logic [3:0] OP_PUSH = 4'd4;
  localparam logic [3:0] OP_JSRP = 4'd5;
  localparam logic [3:0] OP_CJV  = 4'd6;
  localparam logic [3:0] OP_JRP  = 4'd7;
  localparam logic [3:0] OP_RFCT = 4'd8;
  localparam logic [3:0] OP_RPCT = 4'd9;
  localparam logic [3:0] OP_CRTN = 4'd10;
  localparam logic [3:0] OP_CJPP = 4'd11;
  localparam logic [3:0] OP_LDCT = 4'd12;
  localparam logic [3:0] OP_LOOP = 4'd13;
  localparam logic [3:0] OP_CONT = 4'd14;
  localparam logic [3:0] OP_TWB  = 4'd15;

  typedef enum logic [1:0] {
    ST_CLR   = 2'd0,
    ST_IDLE  = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

  typedef struct packed {
    logic push;
    logic pop;
    logic load;
    logic decr;
  } dec_t;

  // load/decr here exclude the RLD_BAR term, which the caller folds in.
  function automatic dec_t am2910_decode(input logic [3:0] op, input logic fail, input logic rz);
    dec_t d;
    d.push = (~fail & (op == OP_CJS)) | (op == OP_PUSH) | (op == OP_JSRP);
    d.pop  = (~fail & ((op == OP_CRTN) | (op == OP_CJPP) | (op == OP_LOOP) | (op == OP_TWB)))
           | (~rz & ((op == OP_RFCT) | (op == OP_TWB)));
    d.load = (op == OP_LDCT) | (~fail & (op == OP_PUSH));
    d.decr = rz & ((op == OP_RFCT) | (op == OP_RPCT) | (op == OP_TWB));
    return d;
  endfunction

endpackage

// File: rtl/am2910_shadow.sv
// Shadow copies of the datapath stack pointer and iteration counter, plus
// sticky overflow/underflow flags and a pre-issue check for the next command.
module am2910_shadow
  import am2910_pkg::*;
#(
  parameter int DW          = 12,
  parameter int STACK_DEPTH = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    chk_op,
  input  logic          chk_ccen_bar,
  input  logic          chk_cc_bar,
  output logic          chk_ovf,
  output logic          chk_unf,
  input  logic          upd_en,
  input  logic [3:0]    upd_op,
  input  logic          upd_ccen_bar,
  input  logic          upd_cc_bar,
  input  logic          upd_rld_bar,
  input  logic          upd_block,
  input  logic [DW-1:0] upd_d,
  output logic [2:0]    depth,
  output logic          err_ovf,
  output logic          err_unf
);

  localparam logic [2:0] FULL = 3'(STACK_DEPTH);

  logic [2:0]    depth_reg, depth_next;
  logic [DW-1:0] re_reg, re_next;
  logic          err_ovf_reg, err_unf_reg;
  dec_t          chk_dec, upd_dec;
  logic          rz, upd_ovf, upd_unf, upd_load, upd_decr;

  assign rz = (re_reg != '0);

  always_comb begin
    chk_dec = am2910_decode(chk_op, chk_cc_bar & ~chk_ccen_bar, rz);
    upd_dec = am2910_decode(upd_op, upd_cc_bar & ~upd_ccen_bar, rz);
  end

  assign chk_ovf  = chk_dec.push && (depth_reg == FULL);
  assign chk_unf  = chk_dec.pop && (depth_reg == 3'd0);
  assign upd_ovf  = upd_dec.push && (depth_reg == FULL);
  assign upd_unf  = upd_dec.pop && (depth_reg == 3'd0);
  assign upd_load = upd_dec.load | ~upd_rld_bar;
  assign upd_decr = upd_dec.decr & upd_rld_bar;

  // Pop wins over push, mirroring the datapath's stack pointer priority.
  always_comb begin
    depth_next = depth_reg;
    re_next    = re_reg;
    if (upd_en && !upd_block) begin
      if (upd_dec.pop && depth_reg != 3'd0)
        depth_next = depth_reg - 3'd1;
      else if (upd_dec.push && depth_reg != FULL)
        depth_next = depth_reg + 3'd1;
      else if (upd_op == OP_JZ)
        depth_next = 3'd0;
      if (upd_load)
        re_next = upd_d;
      else if (upd_decr)
        re_next = re_reg - DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      depth_reg   <= 3'd0;
      re_reg      <= '0;
      err_ovf_reg <= 1'b0;
      err_unf_reg <= 1'b0;
    end else begin
      depth_reg <= depth_next;
      re_reg    <= re_next;
      if (upd_en && upd_ovf) err_ovf_reg <= 1'b1;
      if (upd_en && upd_unf) err_unf_reg <= 1'b1;
    end
  end

  assign depth   = depth_reg;
  assign err_ovf = err_ovf_reg;
  assign err_unf = err_unf_reg;

endmodule

// File: rtl/am2910_issue_ctrl.sv
// Valid/ready command front end for an am2910 datapath: CLR once, then IDLE/ISSUE pairs.
// Optional AM2910_ISSUE_GUARD_EN turns overflowing/underflowing commands into a held CONT.
module am2910_issue_ctrl
  import am2910_pkg::*;
#(
  parameter int   DW          = 12,
  parameter int   STACK_DEPTH = 5,
  parameter logic CI_ISSUE    = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [3:0]    cmd_op,
  input  logic [DW-1:0] cmd_d,
  input  logic          cmd_ccen_bar,
  input  logic          cmd_cc_bar,
  input  logic          cmd_rld_bar,
  output logic [3:0]    seq_i,
  output logic          seq_ccen_bar,
  output logic          seq_cc_bar,
  output logic          seq_rld_bar,
  output logic          seq_ci,
  output logic [DW-1:0] seq_d,
  input  logic [DW-1:0] seq_y,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_y,
  output logic [2:0]    depth,
  output logic          err_ovf,
  output logic          err_unf
);

`ifdef AM2910_ISSUE_GUARD_EN
  localparam logic GUARD_EN = 1'b1;
`else
  localparam logic GUARD_EN = 1'b0;
`endif

  state_t        state_reg, state_next;
  logic          accept, block, upd_en, chk_ovf, chk_unf;

  logic [3:0]    iss_op_reg;
  logic          iss_ccen_bar_reg, iss_cc_bar_reg, iss_rld_bar_reg, iss_block_reg;
  logic [DW-1:0] iss_d_reg;

  logic [3:0]    seq_i_reg, seq_i_next;
  logic          seq_ccen_bar_reg, seq_ccen_bar_next;
  logic          seq_cc_bar_reg, seq_cc_bar_next;
  logic          seq_rld_bar_reg, seq_rld_bar_next;
  logic          seq_ci_reg, seq_ci_next;
  logic [DW-1:0] seq_d_reg, seq_d_next;
  logic          cmd_ready_reg, cmd_ready_next;
  logic          rsp_valid_reg, rsp_valid_next;
  logic [DW-1:0] rsp_y_reg, rsp_y_next;

  assign accept = (state_reg == ST_IDLE) && cmd_valid && cmd_ready_reg;
  assign block  = GUARD_EN & (chk_ovf | chk_unf);
  assign upd_en = (state_reg == ST_ISSUE);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_CLR;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_CLR:   state_next = ST_IDLE;
      ST_IDLE:  if (accept) state_next = ST_ISSUE;
      ST_ISSUE: state_next = ST_IDLE;
      default:  state_next = ST_CLR;
    endcase
  end

  // Output values are chosen for the state being entered so they are registered.
  always_comb begin
    seq_i_next        = OP_CONT;
    seq_ccen_bar_next = 1'b1;
    seq_cc_bar_next   = 1'b1;
    seq_rld_bar_next  = 1'b1;
    seq_ci_next       = 1'b0;
    seq_d_next        = '0;
    cmd_ready_next    = 1'b0;
    case (state_next)
      ST_CLR: begin
        seq_i_next       = OP_JZ;
        seq_rld_bar_next = 1'b0;
      end
      ST_IDLE: cmd_ready_next = 1'b1;
      ST_ISSUE: begin
        seq_i_next        = block ? OP_CONT : cmd_op;
        seq_ccen_bar_next = cmd_ccen_bar;
        seq_cc_bar_next   = cmd_cc_bar;
        seq_rld_bar_next  = block ? 1'b1 : cmd_rld_bar;
        seq_ci_next       = block ? 1'b0 : CI_ISSUE;
        seq_d_next        = cmd_d;
      end
      default: ;
    endcase
    rsp_valid_next = (state_reg == ST_ISSUE);
    rsp_y_next     = (state_reg == ST_ISSUE) ? seq_y : rsp_y_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seq_i_reg        <= OP_JZ;
      seq_ccen_bar_reg <= 1'b1;
      seq_cc_bar_reg   <= 1'b1;
      seq_rld_bar_reg  <= 1'b0;
      seq_ci_reg       <= 1'b0;
      seq_d_reg        <= '0;
      cmd_ready_reg    <= 1'b0;
      rsp_valid_reg    <= 1'b0;
      rsp_y_reg        <= '0;
      iss_op_reg       <= OP_CONT;
      iss_ccen_bar_reg <= 1'b1;
      iss_cc_bar_reg   <= 1'b1;
      iss_rld_bar_reg  <= 1'b1;
      iss_block_reg    <= 1'b0;
      iss_d_reg        <= '0;
    end else begin
      seq_i_reg        <= seq_i_next;
      seq_ccen_bar_reg <= seq_ccen_bar_next;
      seq_cc_bar_reg   <= seq_cc_bar_next;
      seq_rld_bar_reg  <= seq_rld_bar_next;
      seq_ci_reg       <= seq_ci_next;
      seq_d_reg        <= seq_d_next;
      cmd_ready_reg    <= cmd_ready_next;
      rsp_valid_reg    <= rsp_valid_next;
      rsp_y_reg        <= rsp_y_next;
      if (accept) begin
        iss_op_reg       <= cmd_op;
        iss_ccen_bar_reg <= cmd_ccen_bar;
        iss_cc_bar_reg   <= cmd_cc_bar;
        iss_rld_bar_reg  <= cmd_rld_bar;
        iss_block_reg    <= block;
        iss_d_reg        <= cmd_d;
      end
    end
  end

  am2910_shadow #(
    .DW          (DW),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_shadow (
    .clk          (clk),
    .rst          (rst),
    .chk_op       (cmd_op),
    .chk_ccen_bar (cmd_ccen_bar),
    .chk_cc_bar   (cmd_cc_bar),
    .chk_ovf      (chk_ovf),
    .chk_unf      (chk_unf),
    .upd_en       (upd_en),
    .upd_op       (iss_op_reg),
    .upd_ccen_bar (iss_ccen_bar_reg),
    .upd_cc_bar   (iss_cc_bar_reg),
    .upd_rld_bar  (iss_rld_bar_reg),
    .upd_block    (iss_block_reg),
    .upd_d        (iss_d_reg),
    .depth        (depth),
    .err_ovf      (err_ovf),
    .err_unf      (err_unf)
  );

  assign cmd_ready    = cmd_ready_reg;
  assign seq_i        = seq_i_reg;
  assign seq_ccen_bar = seq_ccen_bar_reg;
  assign seq_cc_bar   = seq_cc_bar_reg;
  assign seq_rld_bar  = seq_rld_bar_reg;
  assign seq_ci       = seq_ci_reg;
  assign seq_d        = seq_d_reg;
  assign rsp_valid    = rsp_valid_reg;
  assign rsp_y        = rsp_y_reg;

endmodule

// File: tb/tb_am2910_issue_ctrl.sv
// Bench for am2910_issue_ctrl: behavioural am2910 datapath drives seq_y, and a
// per-command reference model predicts rsp_y, depth and the error flags.
module tb_am2910_issue_ctrl;
  localparam int DW = 12;
`ifdef AM2910_ISSUE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef struct packed {
    logic [11:0]      upc;
    logic [11:0]      cnt;
    logic [2:0]       sp;
    logic [5:0][11:0] stk;
  } am_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [3:0] cmd_op = 4'd14;
  logic [DW-1:0] cmd_d = '0;
  logic cmd_ccen_bar = 1'b1, cmd_cc_bar = 1'b1, cmd_rld_bar = 1'b1;
  logic [3:0] seq_i;
  logic seq_ccen_bar, seq_cc_bar, seq_rld_bar, seq_ci;
  logic [DW-1:0] seq_d, seq_y;
  logic rsp_valid;
  logic [DW-1:0] rsp_y;
  logic [2:0] depth;
  logic err_ovf, err_unf;

  int n_pass = 0;
  int n_total = 0;
  am_t dp = '0;
  am_t ref_st = '0;
  bit exp_ovf = 1'b0, exp_unf = 1'b0;

  always #5 clk = ~clk;

  am2910_issue_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_d(cmd_d), .cmd_ccen_bar(cmd_ccen_bar), .cmd_cc_bar(cmd_cc_bar), .cmd_rld_bar(cmd_rld_bar),
    .seq_i(seq_i), .seq_ccen_bar(seq_ccen_bar), .seq_cc_bar(seq_cc_bar), .seq_rld_bar(seq_rld_bar),
    .seq_ci(seq_ci), .seq_d(seq_d), .seq_y(seq_y), .rsp_valid(rsp_valid), .rsp_y(rsp_y),
    .depth(depth), .err_ovf(err_ovf), .err_unf(err_unf)
  );

  function automatic bit f_push(logic [3:0] op, logic pass);
    return (op == 4'd1 && pass) || op == 4'd4 || op == 4'd5;
  endfunction

  function automatic bit f_pop(logic [3:0] op, logic pass, logic rz);
    case (op)
      4'd8:               return !rz;
      4'd10, 4'd11, 4'd13: return pass;
      4'd15:              return pass || !rz;
      default:            return 1'b0;
    endcase
  endfunction

  function automatic logic [11:0] am_y(am_t s, logic [3:0] op, logic pass, logic [11:0] d);
    logic rz;
    logic [11:0] f;
    rz = (s.cnt != 0);
    f = s.stk[s.sp];
    case (op)
      4'd0:                return 12'd0;
      4'd1, 4'd3, 4'd6, 4'd11: return pass ? d : s.upc;
      4'd2:                return d;
      4'd5, 4'd7:          return pass ? d : s.cnt;
      4'd8:                return rz ? f : s.upc;
      4'd9:                return rz ? d : s.upc;
      4'd10:               return pass ? f : s.upc;
      4'd13:               return pass ? s.upc : f;
      4'd15:               return pass ? s.upc : (rz ? f : d);
      default:             return s.upc;
    endcase
  endfunction

  function automatic am_t am_next(am_t s, logic [3:0] op, logic pass, logic rld_bar, logic [11:0] d, logic ci);
    am_t n;
    logic rz;
    n = s;
    rz = (s.cnt != 0);
    if (f_pop(op, pass, rz)) begin
      if (n.sp != 0) n.sp = n.sp - 3'd1;
    end else if (f_push(op, pass)) begin
      if (n.sp != 3'd5) n.sp = n.sp + 3'd1;
      n.stk[n.sp] = s.upc;
    end
    if (op == 4'd0) n.sp = 3'd0;
    if (!rld_bar || op == 4'd12 || (op == 4'd4 && pass)) n.cnt = d;
    else if (rld_bar && rz && (op == 4'd8 || op == 4'd9 || op == 4'd15)) n.cnt = s.cnt - 12'd1;
    n.upc = am_y(s, op, pass, d) + {11'd0, ci};
    return n;
  endfunction

  // Behavioural datapath fed by whatever the controller drives.
  assign seq_y = am_y(dp, seq_i, !(seq_cc_bar && !seq_ccen_bar), seq_d);
  always @(posedge clk) dp <= am_next(dp, seq_i, !(seq_cc_bar && !seq_ccen_bar), seq_rld_bar, seq_d, seq_ci);

  task automatic ref_reset();
    ref_st.upc = 12'd0;
    ref_st.cnt = 12'd0;
    ref_st.sp = 3'd0;
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
  endtask

  task automatic ref_issue(input logic [3:0] op, input logic ccen, input logic cc, input logic rld,
                           input logic [11:0] d, output logic [11:0] y, output bit blk);
    logic pass;
    bit ovf, unf;
    pass = !(cc && !ccen);
    ovf = f_push(op, pass) && ref_st.sp == 3'd5;
    unf = f_pop(op, pass, ref_st.cnt != 0) && ref_st.sp == 3'd0;
    if (ovf) exp_ovf = 1'b1;
    if (unf) exp_unf = 1'b1;
    blk = GUARD && (ovf || unf);
    if (blk) y = ref_st.upc;
    else begin
      y = am_y(ref_st, op, pass, d);
      ref_st = am_next(ref_st, op, pass, rld, d, 1'b1);
    end
  endtask

  // Handshake one command; outputs stay X if acceptance or the response never comes.
  task automatic issue(input logic [3:0] op, input logic ccen, input logic cc, input logic rld,
                       input logic [11:0] d, output logic [11:0] got_y, output logic [3:0] got_i);
    bit acc;
    acc = 1'b0;
    got_y = 'x;
    got_i = 'x;
    cmd_op = op; cmd_ccen_bar = ccen; cmd_cc_bar = cc; cmd_rld_bar = rld; cmd_d = d;
    cmd_valid = 1'b1;
    for (int n = 0; n < 10 && !acc; n++) begin
      if (cmd_ready) acc = 1'b1;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    if (acc) begin
      got_i = seq_i;
      @(posedge clk); #1;
      if (rsp_valid) got_y = rsp_y;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_total++; if (seq_i !== 4'd0) $display("FAIL clr_seq_i: got %0d want 0", seq_i); else n_pass++;
    n_total++; if (seq_rld_bar !== 1'b0) $display("FAIL clr_rld_bar: got %b want 0", seq_rld_bar); else n_pass++;
    n_total++; if (cmd_ready !== 1'b0) $display("FAIL clr_ready: got %b want 0", cmd_ready); else n_pass++;
    n_total++; if ({rsp_valid, err_ovf, err_unf} !== 3'b000) $display("FAIL rst_flags: got %b want 000", {rsp_valid, err_ovf, err_unf}); else n_pass++;
    @(posedge clk); #1;
    n_total++; if ({seq_i, seq_ci, cmd_ready} !== {4'd14, 1'b0, 1'b1}) $display("FAIL idle_pattern: got i=%0d ci=%b rdy=%b want i=14 ci=0 rdy=1", seq_i, seq_ci, cmd_ready); else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (depth !== 3'd0) $display("FAIL rst_depth: got %0d want 0", depth); else n_pass++;
    ref_reset();
  endtask

  task automatic test_cont_push();
    logic [11:0] y, ey;
    logic [3:0] gi;
    bit blk;
    for (int k = 0; k < 3; k++) begin
      ref_issue(4'd14, 1'b1, 1'b1, 1'b1, 12'd0, ey, blk);
      issue(4'd14, 1'b1, 1'b1, 1'b1, 12'd0, y, gi);
      n_total++; if (y !== 12'(k) || y !== ey) $display("FAIL cont_y%0d: got %0h want %0h", k, y, k); else n_pass++;
    end
    ref_issue(4'd4, 1'b1, 1'b1, 1'b1, 12'h007, ey, blk);
    issue(4'd4, 1'b1, 1'b1, 1'b1, 12'h007, y, gi);
    n_total++; if (y !== 12'd3 || y !== ey) $display("FAIL push_y: got %0h want 3", y); else n_pass++;
    n_total++; if (gi !== (blk ? 4'd14 : 4'd4)) $display("FAIL push_seq_i: got %0d want 4", gi); else n_pass++;
    n_total++; if (depth !== 3'd1) $display("FAIL push_depth: got %0d want 1", depth); else n_pass++;
  endtask

  task automatic test_rfct();
    logic [11:0] y, ey;
    logic [3:0] gi;
    bit blk;
    for (int k = 0; k < 8; k++) begin
      ref_issue(4'd8, 1'b1, 1'b1, 1'b1, 12'd0, ey, blk);
      issue(4'd8, 1'b1, 1'b1, 1'b1, 12'd0, y, gi);
      n_total++; if (y !== ((k < 7) ? 12'd3 : 12'd4) || y !== ey || gi !== 4'd8 || blk)
        $display("FAIL rfct_y%0d: got y=%0h i=%0d want y=%0h i=8", k, y, gi, (k < 7) ? 3 : 4); else n_pass++;
    end
    n_total++; if (depth !== 3'd0) $display("FAIL rfct_depth: got %0d want 0", depth); else n_pass++;
    n_total++; if (err_unf !== 1'b0) $display("FAIL rfct_unf: got %b want 0", err_unf); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [11:0] y, ey;
    logic [3:0] gi;
    bit blk;
    for (int k = 0; k < 6; k++) begin
      ref_issue(4'd4, 1'b1, 1'b1, 1'b1, 12'h010, ey, blk);
      issue(4'd4, 1'b1, 1'b1, 1'b1, 12'h010, y, gi);
      n_total++; if (y !== ey) $display("FAIL ovf_y%0d: got %0h want %0h", k, y, ey); else n_pass++;
      n_total++; if (depth !== ((k < 5) ? 3'(k + 1) : 3'd5)) $display("FAIL ovf_depth%0d: got %0d want %0d", k, depth, (k < 5) ? k + 1 : 5); else n_pass++;
      n_total++; if (err_ovf !== (k == 5)) $display("FAIL ovf_flag%0d: got %b want %b", k, err_ovf, k == 5); else n_pass++;
    end
    n_total++; if (gi !== (GUARD ? 4'd14 : 4'd4) || blk !== GUARD) $display("FAIL ovf_seq_i: got %0d want %0d", gi, GUARD ? 14 : 4); else n_pass++;
  endtask

  task automatic test_underflow();
    logic [11:0] y, ey;
    logic [3:0] gi;
    bit blk;
    ref_issue(4'd0, 1'b1, 1'b1, 1'b1, 12'd0, ey, blk);
    issue(4'd0, 1'b1, 1'b1, 1'b1, 12'd0, y, gi);
    n_total++; if (y !== 12'd0 || depth !== 3'd0 || y !== ey) $display("FAIL jz: got y=%0h depth=%0d want y=0 depth=0", y, depth); else n_pass++;
    ref_issue(4'd10, 1'b0, 1'b0, 1'b1, 12'd0, ey, blk);
    issue(4'd10, 1'b0, 1'b0, 1'b1, 12'd0, y, gi);
    n_total++; if (err_unf !== 1'b1) $display("FAIL unf_flag: got %b want 1", err_unf); else n_pass++;
    n_total++; if (depth !== 3'd0) $display("FAIL unf_depth: got %0d want 0", depth); else n_pass++;
    n_total++; if (y !== ey) $display("FAIL unf_y: got %0h want %0h", y, ey); else n_pass++;
    n_total++; if (gi !== (blk ? 4'd14 : 4'd10)) $display("FAIL unf_seq_i: got %0d want %0d", gi, blk ? 14 : 10); else n_pass++;
  endtask

  task automatic test_rst_in_issue();
    bit acc;
    acc = 1'b0;
    cmd_op = 4'd3; cmd_ccen_bar = 1'b0; cmd_cc_bar = 1'b1; cmd_rld_bar = 1'b1; cmd_d = 12'h0AA;
    cmd_valid = 1'b1;
    for (int n = 0; n < 10 && !acc; n++) begin
      if (cmd_ready) acc = 1'b1;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    n_total++; if (seq_i !== 4'd3 || seq_d !== 12'h0AA) $display("FAIL cjp_issue: got i=%0d d=%0h want i=3 d=aa", seq_i, seq_d); else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL rst_issue_rsp: got %b want 0", rsp_valid); else n_pass++;
    n_total++; if (seq_i !== 4'd0 || seq_rld_bar !== 1'b0) $display("FAIL rst_issue_clr: got i=%0d rld=%b want i=0 rld=0", seq_i, seq_rld_bar); else n_pass++;
    n_total++; if ({err_ovf, err_unf, depth} !== 5'd0) $display("FAIL rst_issue_flags: got ovf=%b unf=%b depth=%0d want 0 0 0", err_ovf, err_unf, depth); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (rsp_valid !== 1'b0 || seq_i !== 4'd14) $display("FAIL rst_issue_after: got v=%b i=%0d want v=0 i=14", rsp_valid, seq_i); else n_pass++;
    ref_reset();
  endtask

  task automatic test_random();
    logic [11:0] y, ey, d;
    logic [3:0] gi, op;
    logic ccen, cc, rld;
    bit blk;
    for (int k = 0; k < 60; k++) begin
      op = 4'($urandom_range(0, 15));
      ccen = 1'($urandom);
      cc = 1'($urandom);
      rld = ($urandom_range(0, 3) != 0);
      d = 12'($urandom);
      ref_issue(op, ccen, cc, rld, d, ey, blk);
      issue(op, ccen, cc, rld, d, y, gi);
      n_total++; if (y !== ey || gi !== (blk ? 4'd14 : op))
        $display("FAIL rand%0d op=%0d: got y=%0h i=%0d want y=%0h i=%0d", k, op, y, gi, ey, blk ? 14 : op); else n_pass++;
      n_total++; if (depth !== ref_st.sp || err_ovf !== exp_ovf || err_unf !== exp_unf || cmd_ready !== 1'b1)
        $display("FAIL rand%0d state: got depth=%0d ovf=%b unf=%b rdy=%b want %0d %b %b 1", k, depth, err_ovf, err_unf, cmd_ready, ref_st.sp, exp_ovf, exp_unf); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_cont_push();
    test_rfct();
    test_overflow();
    test_underflow();
    test_rst_in_issue();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
